store_byte_unit: RTL and testbench

STORE_BYTE_UNIT -- requirements
Module: store_byte_unit

---
 rtl/store_byte_unit_pkg.sv | 24 ++
 rtl/store_byte_unit_if.sv | 27 ++
 rtl/store_byte_unit_byte_merge.sv | 28 ++
 rtl/store_byte_unit.sv | 101 ++++++++++
 tb/tb_store_byte_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/store_byte_unit_pkg.sv
// Shared constants and types for the store-byte path between core and dmem.
// Holds the FSM state encoding, lane geometry and the lane-to-slot helper.
// Pure declarations, no logic of its own.
package store_byte_unit_pkg;

   // Memory-access geometry: 32-bit words made of four 8-bit lanes.
   localparam int WORD_W = 32;
   localparam int LANE_W = 8;
   localparam int LANES  = WORD_W / LANE_W;

   // Byte-store sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } sbu_state_t;

   // Physical byte slot inside the word for an address lane.
   // Big-endian puts lane 0 in the top byte, so the slot is the lane mirrored.
   function automatic logic [1:0] lane_slot(input logic [1:0] lane, input bit big_endian);
      return big_endian ? ~lane : lane;
   endfunction

endpackage

// File: rtl/store_byte_unit_if.sv
// Core-side store request and dmem-side port bundle for store_byte_unit.
// master = core + dmem environment, slave = the store-byte unit.
// ReadData is a combinational read of dmem at MemAdr.
interface store_byte_unit_if;
   // core side
   logic        MemWrite;
   logic        B;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic        Stall;
   logic [15:0] ByteCount;
   // dmem side
   logic [31:0] MemAdr;
   logic        MemWe;
   logic [31:0] MemWd;
   logic [31:0] ReadData;

   modport master (
      output MemWrite, B, DataAdr, WriteData, ReadData,
      input  Stall, ByteCount, MemAdr, MemWe, MemWd
   );

   modport slave (
      input  MemWrite, B, DataAdr, WriteData, ReadData,
      output Stall, ByteCount, MemAdr, MemWe, MemWd
   );
endinterface

// File: rtl/store_byte_unit_byte_merge.sv
// Byte merge: replaces one lane of an old word with a new byte (inverse of load-byte extract).
// Latency: combinational.
// No flow control; pure function of its inputs.
module store_byte_unit_byte_merge
   import store_byte_unit_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic [WORD_W-1:0] old_word,
   input  logic [LANE_W-1:0] byte_dat,
   input  logic [1:0]        lane,
   output logic [WORD_W-1:0] merged_word
);

   logic [1:0] slot;
   assign slot = lane_slot(lane, BIG_ENDIAN);

   // Overwrite only the addressed slot; the other three lanes pass through.
   always_comb begin
      merged_word = old_word;
      for (int i = 0; i < LANES; i++) begin
         if (slot == i[1:0]) begin
            merged_word[i*LANE_W +: LANE_W] = byte_dat;
         end
      end
   end

endmodule

// File: rtl/store_byte_unit.sv
// Store-byte unit: word stores pass straight through; byte stores do read-modify-write.
// Latency: word store 0 cycles; byte store 3 cycles (detect, READ, WRITE).
// Backpressure: Stall held high for the detect and READ cycles of a byte store.
module store_byte_unit
   import store_byte_unit_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   store_byte_unit_if.slave bus
);

   sbu_state_t        state_q, state_d;
   logic [31:0]       word_adr_q, word_adr_d;
   logic [1:0]        lane_q, lane_d;
   logic [LANE_W-1:0] byte_q, byte_d;
   logic [31:0]       old_word_q, old_word_d;
   logic [15:0]       byte_cnt_q, byte_cnt_d;
   logic [31:0]       merged_word;

   store_byte_unit_byte_merge #(.BIG_ENDIAN(BIG_ENDIAN)) u_merge (
      .old_word    (old_word_q),
      .byte_dat    (byte_q),
      .lane        (lane_q),
      .merged_word (merged_word)
   );

   // Next-state: latch request in IDLE, capture old word in READ, count on leaving WRITE.
   always_comb begin
      state_d    = state_q;
      word_adr_d = word_adr_q;
      lane_d     = lane_q;
      byte_d     = byte_q;
      old_word_d = old_word_q;
      byte_cnt_d = byte_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.MemWrite && bus.B) begin
               word_adr_d = {bus.DataAdr[31:2], 2'b00};
               lane_d     = bus.DataAdr[1:0];
               byte_d     = bus.WriteData[LANE_W-1:0];
               state_d    = ST_READ;
            end
         end
         ST_READ: begin
            old_word_d = bus.ReadData;
            state_d    = ST_WRITE;
         end
         ST_WRITE: begin
            state_d = ST_IDLE;
            if (byte_cnt_q != 16'hFFFF) begin
               byte_cnt_d = byte_cnt_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; synchronous reset aborts any byte store in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         word_adr_q <= '0;
         lane_q     <= '0;
         byte_q     <= '0;
         old_word_q <= '0;
         byte_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         word_adr_q <= word_adr_d;
         lane_q     <= lane_d;
         byte_q     <= byte_d;
         old_word_q <= old_word_d;
         byte_cnt_q <= byte_cnt_d;
      end
   end

   // Output decode; while reset is low the unit looks idle and never writes.
   always_comb begin
      bus.MemAdr = bus.DataAdr;
      bus.MemWd  = bus.WriteData;
      bus.MemWe  = 1'b0;
      bus.Stall  = 1'b0;
      if (!reset || state_q == ST_IDLE || state_q > ST_WRITE) begin
         bus.MemWe = reset && bus.MemWrite && !bus.B;
         bus.Stall = bus.MemWrite && bus.B;
      end else if (state_q == ST_READ) begin
         bus.MemAdr = word_adr_q;
         bus.MemWd  = merged_word;
         bus.Stall  = 1'b1;
      end else begin
         bus.MemAdr = word_adr_q;
         bus.MemWd  = merged_word;
         bus.MemWe  = 1'b1;
      end
   end

   assign bus.ByteCount = byte_cnt_q;

endmodule

// File: tb/tb_store_byte_unit.sv
// Bench for store_byte_unit: little- and big-endian instances driven in lockstep.
// Each instance has its own dmem array; a word-level reference memory predicts contents.
// Byte merges are predicted with mask/shift arithmetic on the reference memory.
module tb_store_byte_unit;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic        mw = 1'b0;
   logic        b = 1'b0;
   logic [31:0] adr = '0;
   logic [31:0] wd = '0;

   store_byte_unit_if if_le();
   store_byte_unit_if if_be();

   assign if_le.MemWrite  = mw;
   assign if_le.B         = b;
   assign if_le.DataAdr   = adr;
   assign if_le.WriteData = wd;
   assign if_be.MemWrite  = mw;
   assign if_be.B         = b;
   assign if_be.DataAdr   = adr;
   assign if_be.WriteData = wd;

   store_byte_unit #(.BIG_ENDIAN(1'b0)) dut_le (.clk(clk), .reset(reset), .bus(if_le.slave));
   store_byte_unit #(.BIG_ENDIAN(1'b1)) dut_be (.clk(clk), .reset(reset), .bus(if_be.slave));

   // dmem models: combinational read, write on rising edge
   logic [31:0] mem_le [0:63];
   logic [31:0] mem_be [0:63];
   assign if_le.ReadData = mem_le[if_le.MemAdr[7:2]];
   assign if_be.ReadData = mem_be[if_be.MemAdr[7:2]];
   always @(posedge clk) begin
      if (if_le.MemWe) mem_le[if_le.MemAdr[7:2]] <= if_le.MemWd;
      if (if_be.MemWe) mem_be[if_be.MemAdr[7:2]] <= if_be.MemWd;
   end

   // reference model state
   logic [31:0] ref_le [0:63];
   logic [31:0] ref_be [0:63];
   int unsigned ref_cnt = 0;

   int n_chk = 0;
   int n_fail = 0;
   int unsigned cycles = 0;
   always @(posedge clk) cycles <= cycles + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [7:0] d,
                                              input logic [1:0] lane, input bit be);
      int sh;
      sh = be ? 8 * (3 - int'(lane)) : 8 * int'(lane);
      return (old & ~(32'h000000FF << sh)) | ({24'h0, d} << sh);
   endfunction

   task automatic scramble();
      mw  = 1'($urandom);
      b   = 1'($urandom);
      adr = $urandom;
      wd  = $urandom;
   endtask

   // All tasks start and end 1 time unit after a rising edge.
   task automatic idle_cycle();
      mw = 1'b0; b = 1'($urandom); adr = $urandom; wd = $urandom;
      #1;
      chk("idle_we", 32'(if_le.MemWe), 32'd0);
      chk("idle_stall", 32'(if_le.Stall), 32'd0);
      chk("idle_adr", if_le.MemAdr, adr);
      @(posedge clk); #1;
   endtask

   task automatic word_store(input logic [31:0] a, input logic [31:0] d);
      mw = 1'b1; b = 1'b0; adr = a; wd = d;
      #1;
      chk("word_we_le", 32'(if_le.MemWe), 32'd1);
      chk("word_we_be", 32'(if_be.MemWe), 32'd1);
      chk("word_wd", if_le.MemWd, d);
      chk("word_adr", if_be.MemAdr, a);
      chk("word_stall", 32'(if_le.Stall), 32'd0);
      @(posedge clk); #1;
      mw = 1'b0;
      ref_le[a[7:2]] = d;
      ref_be[a[7:2]] = d;
      chk("word_cnt", 32'(if_le.ByteCount), ref_cnt);
   endtask

   task automatic byte_store(input logic [31:0] a, input logic [7:0] d);
      logic [31:0] wa;
      logic [31:0] exp_le;
      logic [31:0] exp_be;
      wa = {a[31:2], 2'b00};
      exp_le = merge_ref(ref_le[a[7:2]], d, a[1:0], 1'b0);
      exp_be = merge_ref(ref_be[a[7:2]], d, a[1:0], 1'b1);
      mw = 1'b1; b = 1'b1; adr = a; wd = $urandom; wd[7:0] = d;
      #1;
      chk("det_stall", 32'(if_le.Stall), 32'd1);
      chk("det_we", 32'(if_be.MemWe | if_le.MemWe), 32'd0);
      @(posedge clk); #1;
      scramble();
      #1;
      chk("rd_stall", 32'(if_be.Stall), 32'd1);
      chk("rd_we", 32'(if_le.MemWe | if_be.MemWe), 32'd0);
      chk("rd_adr", if_le.MemAdr, wa);
      @(posedge clk); #1;
      scramble();
      #1;
      chk("wr_we", 32'(if_le.MemWe & if_be.MemWe), 32'd1);
      chk("wr_stall", 32'(if_le.Stall | if_be.Stall), 32'd0);
      chk("wr_adr", if_be.MemAdr, wa);
      chk("wr_wd_le", if_le.MemWd, exp_le);
      chk("wr_wd_be", if_be.MemWd, exp_be);
      @(posedge clk); #1;
      mw = 1'b0; b = 1'b0;
      ref_le[a[7:2]] = exp_le;
      ref_be[a[7:2]] = exp_be;
      if (ref_cnt != 32'hFFFF) ref_cnt++;
      chk("byte_cnt_le", 32'(if_le.ByteCount), ref_cnt);
      chk("byte_cnt_be", 32'(if_be.ByteCount), ref_cnt);
      chk("byte_mem_le", mem_le[a[7:2]], ref_le[a[7:2]]);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t0;
      int unsigned sel;
      logic [31:0] a;
      for (int i = 0; i < 64; i++) begin
         mem_le[i] = '0; mem_be[i] = '0; ref_le[i] = '0; ref_be[i] = '0;
      end

      // reset: counter clear, outputs decode as idle but never write
      mw = 1'b1; b = 1'b0; adr = 32'h0000_0044; wd = 32'hCAFE_F00D;
      @(posedge clk); @(posedge clk); #1;
      #1;
      chk("rst_cnt", 32'(if_le.ByteCount), 32'd0);
      chk("rst_we", 32'(if_le.MemWe | if_be.MemWe), 32'd0);
      chk("rst_adr", if_le.MemAdr, 32'h0000_0044);
      chk("rst_stall", 32'(if_le.Stall), 32'd0);
      mw = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // word store passthrough
      word_store(32'h40, 32'hDEADBEEF);
      chk("req31_mem", mem_le[16], 32'hDEADBEEF);

      // single byte store, both endiannesses
      word_store(32'h40, 32'h11223344);
      byte_store(32'h42, 8'hAB);
      chk("req32_le", mem_le[16], 32'h11AB3344);
      chk("req33_be", mem_be[16], 32'h1122AB44);
      chk("req32_cnt", 32'(if_le.ByteCount), 32'd1);

      // back-to-back byte stores
      word_store(32'h40, 32'h0);
      t0 = cycles;
      for (int i = 0; i < 4; i++) byte_store(32'h40 + i, 8'(i + 1));
      chk("b2b_cycles", cycles - t0, 32'd12);
      chk("b2b_le", mem_le[16], 32'h04030201);
      chk("b2b_be", mem_be[16], 32'h01020304);
      chk("b2b_cnt", 32'(if_le.ByteCount), 32'd5);

      // reset during READ aborts the store
      word_store(32'h44, 32'h55667788);
      mw = 1'b1; b = 1'b1; adr = 32'h45; wd = 32'h000000EE;
      @(posedge clk); #1;
      reset = 1'b0; mw = 1'b1; b = 1'b0; adr = 32'h48; wd = $urandom;
      #1;
      chk("abort_rst_we", 32'(if_le.MemWe | if_be.MemWe), 32'd0);
      chk("abort_rst_adr", if_le.MemAdr, 32'h48);
      @(posedge clk); #1;
      reset = 1'b1; mw = 1'b0; b = 1'b0;
      #1;
      chk("abort_we", 32'(if_le.MemWe | if_be.MemWe), 32'd0);
      chk("abort_stall", 32'(if_le.Stall), 32'd0);
      @(posedge clk); #1;
      ref_cnt = 0;
      chk("abort_cnt", 32'(if_le.ByteCount), 32'd0);
      chk("abort_mem", mem_le[17], 32'h55667788);
      chk("abort_mem48", mem_le[18], ref_le[18]);
      byte_store(32'h47, 8'h99);

      // saturation from a preloaded counter
      force dut_le.byte_cnt_q = 16'hFFFD;
      force dut_be.byte_cnt_q = 16'hFFFD;
      #1;
      release dut_le.byte_cnt_q;
      release dut_be.byte_cnt_q;
      ref_cnt = 32'hFFFD;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) byte_store(32'h50 + i, 8'($urandom));
      chk("sat_cnt", 32'(if_le.ByteCount), 32'hFFFF);
      chk("sat_mem_be", mem_be[20], ref_be[20]);

      // random mix
      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 9);
         a = 32'($urandom_range(0, 255));
         if (sel < 3) idle_cycle();
         else if (sel < 6) word_store({a[31:2], 2'b00}, $urandom);
         else byte_store(a, 8'($urandom));
      end

      for (int i = 0; i < 64; i++) begin
         chk("final_le", mem_le[i], ref_le[i]);
         chk("final_be", mem_be[i], ref_be[i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
